// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - writeback/CSR/fetch-redirect bundle for the exception controller
interface exc_ctrl_if;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_ex;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [31:0] ws_vaddr;
  logic        ws_ertn;
  logic        csr_crmd_ie;
  logic [12:0] csr_ecfg_lie;
  logic [12:0] csr_estat_is;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        ws_ready;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_csr_pc;
  logic [31:0] wb_vaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        int_pending;

  modport master (
    output ws_valid, ws_pc, ws_ex, ws_ecode, ws_esubcode, ws_vaddr, ws_ertn,
           csr_crmd_ie, csr_ecfg_lie, csr_estat_is, ex_entry, ertn_entry, redirect_ready,
    input  ws_ready, wb_ex, ertn_flush, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr,
           flush, redirect_valid, redirect_pc, int_pending
  );

  modport slave (
    input  ws_valid, ws_pc, ws_ex, ws_ecode, ws_esubcode, ws_vaddr, ws_ertn,
           csr_crmd_ie, csr_ecfg_lie, csr_estat_is, ex_entry, ertn_entry, redirect_ready,
    output ws_ready, wb_ex, ertn_flush, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr,
           flush, redirect_valid, redirect_pc, int_pending
  );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt/ERTN commit and fetch-redirect sequencer
module exc_ctrl #(
  parameter int         MIN_FLUSH = 2,
  parameter logic [5:0] ECODE_INT = 6'h00
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, COMMIT = 2'd1, REDIR = 2'd2} state_t;

  localparam logic [3:0] FLUSH_MIN = 4'(MIN_FLUSH);

  state_t     state;
  logic       is_ertn;
  logic [3:0] flush_cnt;
  logic [3:0] cnt_next;
  logic       ev_int;
  logic       ev_ex;
  logic       ev_ertn;
  logic       ev_any;

  assign bus.int_pending = bus.csr_crmd_ie & |(bus.csr_ecfg_lie & bus.csr_estat_is);
  assign bus.ws_ready    = (state == IDLE) & ~reset;

  // Priority: interrupt masks exception, exception masks ERTN.
  always_comb begin
    ev_int   = bus.ws_valid & bus.int_pending;
    ev_ex    = bus.ws_valid & ~bus.int_pending & bus.ws_ex;
    ev_ertn  = bus.ws_valid & ~bus.int_pending & ~bus.ws_ex & bus.ws_ertn;
    ev_any   = ev_int | ev_ex | ev_ertn;
    cnt_next = (flush_cnt == 4'hF) ? flush_cnt : flush_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      is_ertn            <= 1'b0;
      flush_cnt          <= 4'd0;
      bus.wb_ex          <= 1'b0;
      bus.ertn_flush     <= 1'b0;
      bus.wb_ecode       <= 6'd0;
      bus.wb_esubcode    <= 9'd0;
      bus.wb_csr_pc      <= 32'd0;
      bus.wb_vaddr       <= 32'd0;
      bus.flush          <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_any) begin
            state          <= COMMIT;
            is_ertn        <= ev_ertn;
            bus.wb_ex      <= ~ev_ertn;
            bus.ertn_flush <= ev_ertn;
            bus.flush      <= 1'b1;
            flush_cnt      <= 4'd1;
            bus.wb_csr_pc  <= bus.ws_pc;
            if (ev_ex) begin
              bus.wb_ecode    <= bus.ws_ecode;
              bus.wb_esubcode <= bus.ws_esubcode;
              bus.wb_vaddr    <= bus.ws_vaddr;
            end else begin
              bus.wb_ecode    <= ev_int ? ECODE_INT : 6'd0;
              bus.wb_esubcode <= 9'd0;
              bus.wb_vaddr    <= 32'd0;
            end
          end
        end
        COMMIT: begin
          state              <= REDIR;
          bus.wb_ex          <= 1'b0;
          bus.ertn_flush     <= 1'b0;
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc    <= is_ertn ? bus.ertn_entry : bus.ex_entry;
          flush_cnt          <= cnt_next;
        end
        REDIR: begin
          // Fetch may accept early, but the flush must cover the minimum window first.
          if (bus.redirect_ready && (flush_cnt >= FLUSH_MIN)) begin
            state              <= IDLE;
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            flush_cnt          <= 4'd0;
          end else begin
            flush_cnt <= cnt_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
